// File: rtl/rf_pkg.sv
// Shared register-file writeback types: datapath width, register index width
// and the buffered {rd, data} entry.
package rf_pkg;
  localparam int XLEN   = 64;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;
endpackage

// File: rtl/rf_wb_match.sv
// Hazard lookup over the buffered writeback entries for one query port.
// With RF_WRITEBACK_FWD_EN defined it also forwards the youngest matching data.
module rf_wb_match
  import rf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0]             vld,
  input  logic [DEPTH-1:0][REG_AW-1:0] rds,
`ifdef RF_WRITEBACK_FWD_EN
  input  logic [$clog2(DEPTH)-1:0]     head,
  input  logic [DEPTH-1:0][XLEN-1:0]   datas,
`endif
  input  logic [REG_AW-1:0]            addr,
  output logic                         pend,
  output logic [XLEN-1:0]              data
);
  localparam int PW = $clog2(DEPTH);

  always_comb begin
    pend = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && (rds[i] == addr)) pend = 1'b1;
    end
    if (addr == '0) pend = 1'b0;
  end

`ifdef RF_WRITEBACK_FWD_EN
  logic [PW-1:0] idx;

  // Walk oldest to youngest so the last hit is the youngest match.
  always_comb begin
    data = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (vld[idx] && (rds[idx] == addr)) data = datas[idx];
    end
  end
`else
  assign data = '0;
`endif
endmodule

// File: rtl/rf_writeback.sv
// Register-file writeback buffer: FIFO of {rd, data} drained one write per
// free rf cycle, with pending lookups. Optional forwarding: RF_WRITEBACK_FWD_EN.
module rf_writeback
  import rf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [REG_AW-1:0]        in_rd,
  input  logic [XLEN-1:0]          in_data,
  input  logic                     rf_hold,
  output logic                     we,
  output logic [REG_AW-1:0]        wr,
  output logic [XLEN-1:0]          wd,
  input  logic [REG_AW-1:0]        q_addr1,
  input  logic [REG_AW-1:0]        q_addr2,
  output logic                     q_pend1,
  output logic                     q_pend2,
  output logic [XLEN-1:0]          q_data1,
  output logic [XLEN-1:0]          q_data2,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t                   mem [DEPTH];
  logic [DEPTH-1:0]            vld;
  logic [PW-1:0]               head;
  logic [PW-1:0]               tail;
  logic                        push;
  logic                        pop;
  logic                        occupied;
  logic [DEPTH-1:0][REG_AW-1:0] rds;

  assign occupied = (count != '0);
  assign in_ready = (count < CW'(DEPTH));
  // x0 results complete the handshake but are never stored.
  assign push     = in_valid && in_ready && (in_rd != '0);
  assign pop      = rst_n && occupied && !rf_hold;
  assign we       = pop;
  assign wr       = occupied ? mem[head].rd   : '0;
  assign wd       = occupied ? mem[head].data : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
      vld   <= '0;
    end else begin
      if (pop) begin
        vld[head] <= 1'b0;
        head      <= head + PW'(1);
      end
      if (push) begin
        vld[tail] <= 1'b1;
        tail      <= tail + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= '{rd: in_rd, data: in_data};
  end

`ifdef RF_WRITEBACK_FWD_EN
  logic [DEPTH-1:0][XLEN-1:0] datas;
`endif

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign rds[g] = mem[g].rd;
`ifdef RF_WRITEBACK_FWD_EN
    assign datas[g] = mem[g].data;
`endif
  end

  rf_wb_match #(.DEPTH(DEPTH)) u_match1 (
    .vld   (vld),
    .rds   (rds),
`ifdef RF_WRITEBACK_FWD_EN
    .head  (head),
    .datas (datas),
`endif
    .addr  (q_addr1),
    .pend  (q_pend1),
    .data  (q_data1)
  );

  rf_wb_match #(.DEPTH(DEPTH)) u_match2 (
    .vld   (vld),
    .rds   (rds),
`ifdef RF_WRITEBACK_FWD_EN
    .head  (head),
    .datas (datas),
`endif
    .addr  (q_addr2),
    .pend  (q_pend2),
    .data  (q_data2)
  );
endmodule

// File: tb/tb_rf_writeback.sv
// Self-checking bench for rf_writeback against a queue-based model of the
// writeback buffer; forwarding expectations follow RF_WRITEBACK_FWD_EN.
module tb_rf_writeback;
  import rf_pkg::*;

  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_rd;
  logic [63:0]       in_data;
  logic              rf_hold;
  logic              we;
  logic [4:0]        wr;
  logic [63:0]       wd;
  logic [4:0]        q_addr1, q_addr2;
  logic              q_pend1, q_pend2;
  logic [63:0]       q_data1, q_data2;
  logic [2:0]        count;

  int n_checks = 0;
  int n_fail   = 0;

  wb_entry_t model[$];

  always #5 clk = ~clk;

  rf_writeback #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_data(in_data), .rf_hold(rf_hold),
    .we(we), .wr(wr), .wd(wd),
    .q_addr1(q_addr1), .q_addr2(q_addr2),
    .q_pend1(q_pend1), .q_pend2(q_pend2),
    .q_data1(q_data1), .q_data2(q_data2),
    .count(count)
  );

  function automatic logic m_pend(input logic [4:0] a);
    foreach (model[i]) if (a != 0 && model[i].rd == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] m_data(input logic [4:0] a);
    logic [63:0] r = '0;
`ifdef RF_WRITEBACK_FWD_EN
    foreach (model[i]) if (a != 0 && model[i].rd == a) r = model[i].data;
`endif
    return r;
  endfunction

  // One clock edge: update the model from the inputs seen at the edge.
  task automatic advance();
    bit acc, pp;
    acc = in_valid && (model.size() < DEPTH);
    pp  = rst_n && (model.size() != 0) && !rf_hold;
    @(posedge clk);
    if (!rst_n) model.delete();
    else begin
      if (pp) void'(model.pop_front());
      if (acc && in_rd != 0) model.push_back('{rd: in_rd, data: in_data});
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_rd = '0; in_data = '0; rf_hold = 1'b0;
    q_addr1 = 5'd3; q_addr2 = 5'd0;
    repeat (2) advance();
    rst_n = 1'b1; #1;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", we); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
    n_checks++; if (q_pend1 !== 1'b0) begin n_fail++; $display("FAIL reset_pend1: got %b expected 0", q_pend1); end
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_rd = 5'd2; in_data = 64'd10; #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b expected 1", in_ready); end
    advance();
    in_valid = 1'b0; #1;
    n_checks++; if (we !== 1'b1) begin n_fail++; $display("FAIL single_we: got %b expected 1", we); end
    n_checks++; if (wr !== 5'd2) begin n_fail++; $display("FAIL single_wr: got %0d expected 2", wr); end
    n_checks++; if (wd !== 64'd10) begin n_fail++; $display("FAIL single_wd: got %0d expected 10", wd); end
    advance(); #1;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL single_count: got %0d expected 0", count); end
    n_checks++; if (wr !== 5'd0 || wd !== 64'd0) begin n_fail++; $display("FAIL single_empty_wrwd: got %0d/%0h expected 0/0", wr, wd); end
  endtask

  task automatic test_full();
    logic [63:0] exp_d [5];
    rf_hold = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      exp_d[k] = {$urandom, $urandom};
      in_valid = 1'b1; in_rd = 5'(k); in_data = exp_d[k];
      advance();
    end
    in_valid = 1'b1; in_rd = 5'd9; in_data = 64'hdead; #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b expected 0", in_ready); end
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d expected 4", count); end
    advance();
    in_valid = 1'b0; #1;
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_fifth_taken: got count %0d expected 4", count); end
    n_checks++; if (q_pend1 !== 1'b0 && q_addr1 == 5'd9) begin n_fail++; $display("FAIL full_fifth_pend: got %b expected 0", q_pend1); end
    rf_hold = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      #1;
      n_checks++; if (we !== 1'b1) begin n_fail++; $display("FAIL full_drain_we%0d: got %b expected 1", k, we); end
      n_checks++; if (wr !== 5'(k)) begin n_fail++; $display("FAIL full_drain_wr%0d: got %0d expected %0d", k, wr, k); end
      n_checks++; if (wd !== exp_d[k]) begin n_fail++; $display("FAIL full_drain_wd%0d: got %0h expected %0h", k, wd, exp_d[k]); end
      advance();
    end
    #1;
    n_checks++; if (we !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL full_after: got we=%b count=%0d expected 0/0", we, count); end
  endtask

  task automatic test_x0();
    in_valid = 1'b1; in_rd = 5'd0; in_data = 64'd99; #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready: got %b expected 1", in_ready); end
    advance();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL x0_we: got %b expected 0", we); end
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL x0_count: got %0d expected 0", count); end
      advance();
    end
  endtask

  task automatic test_fwd();
    logic [63:0] exp9;
`ifdef RF_WRITEBACK_FWD_EN
    exp9 = 64'd9;
`else
    exp9 = 64'd0;
`endif
    rf_hold = 1'b1;
    in_valid = 1'b1; in_rd = 5'd5; in_data = 64'd7; advance();
    in_rd = 5'd5; in_data = 64'd9; advance();
    in_valid = 1'b0; q_addr1 = 5'd5; q_addr2 = 5'd0; #1;
    n_checks++; if (q_pend1 !== 1'b1) begin n_fail++; $display("FAIL fwd_pend1: got %b expected 1", q_pend1); end
    n_checks++; if (q_data1 !== exp9) begin n_fail++; $display("FAIL fwd_data1: got %0d expected %0d", q_data1, exp9); end
    n_checks++; if (q_pend2 !== 1'b0 || q_data2 !== 64'd0) begin n_fail++; $display("FAIL fwd_x0_query: got %b/%0d expected 0/0", q_pend2, q_data2); end
    rf_hold = 1'b0; advance(); #1;
    n_checks++; if (q_pend1 !== 1'b1 || q_data1 !== exp9) begin n_fail++; $display("FAIL fwd_after_pop: got %b/%0d expected 1/%0d", q_pend1, q_data1, exp9); end
    advance(); #1;
    n_checks++; if (q_pend1 !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL fwd_drained: got pend=%b count=%0d expected 0/0", q_pend1, count); end
  endtask

  task automatic test_midreset();
    rf_hold = 1'b1;
    for (int k = 6; k <= 8; k++) begin
      in_valid = 1'b1; in_rd = 5'(k); in_data = {$urandom, $urandom}; advance();
    end
    in_valid = 1'b0; q_addr1 = 5'd7; q_addr2 = 5'd8; #1;
    n_checks++; if (count !== 3'd3 || q_pend1 !== 1'b1) begin n_fail++; $display("FAIL mid_setup: got count=%0d pend1=%b expected 3/1", count, q_pend1); end
    rf_hold = 1'b0; rst_n = 1'b0; #1;
    n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL mid_we_in_reset: got %b expected 0", we); end
    advance();
    rst_n = 1'b1; #1;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL mid_count: got %0d expected 0", count); end
    n_checks++; if (q_pend1 !== 1'b0 || q_pend2 !== 1'b0) begin n_fail++; $display("FAIL mid_pend: got %b/%b expected 0/0", q_pend1, q_pend2); end
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL mid_we_after: got %b expected 0", we); end
      advance(); #1;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_rd    = 5'($urandom_range(0, 7));
      in_data  = {$urandom, $urandom};
      rf_hold  = ($urandom_range(0, 9) < 4);
      q_addr1  = 5'($urandom_range(0, 7));
      q_addr2  = 5'($urandom_range(0, 7));
      #1;
      n_checks++; if (in_ready !== (model.size() < DEPTH)) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b expected %b", c, in_ready, model.size() < DEPTH); end
      n_checks++; if (count !== 3'(model.size())) begin n_fail++; $display("FAIL rnd_count c%0d: got %0d expected %0d", c, count, model.size()); end
      n_checks++; if (we !== (model.size() != 0 && !rf_hold)) begin n_fail++; $display("FAIL rnd_we c%0d: got %b expected %b", c, we, (model.size() != 0 && !rf_hold)); end
      n_checks++; if (wr !== (model.size() != 0 ? model[0].rd : 5'd0)) begin n_fail++; $display("FAIL rnd_wr c%0d: got %0d expected %0d", c, wr, (model.size() != 0 ? model[0].rd : 5'd0)); end
      n_checks++; if (wd !== (model.size() != 0 ? model[0].data : 64'd0)) begin n_fail++; $display("FAIL rnd_wd c%0d: got %0h expected %0h", c, wd, (model.size() != 0 ? model[0].data : 64'd0)); end
      n_checks++; if (q_pend1 !== m_pend(q_addr1)) begin n_fail++; $display("FAIL rnd_pend1 c%0d: got %b expected %b", c, q_pend1, m_pend(q_addr1)); end
      n_checks++; if (q_pend2 !== m_pend(q_addr2)) begin n_fail++; $display("FAIL rnd_pend2 c%0d: got %b expected %b", c, q_pend2, m_pend(q_addr2)); end
      n_checks++; if (q_data1 !== m_data(q_addr1)) begin n_fail++; $display("FAIL rnd_data1 c%0d: got %0h expected %0h", c, q_data1, m_data(q_addr1)); end
      n_checks++; if (q_data2 !== m_data(q_addr2)) begin n_fail++; $display("FAIL rnd_data2 c%0d: got %0h expected %0h", c, q_data2, m_data(q_addr2)); end
      advance();
    end
    in_valid = 1'b0; rf_hold = 1'b0;
    repeat (DEPTH + 2) advance();
    #1;
    n_checks++; if (count !== 3'd0 || model.size() != 0) begin n_fail++; $display("FAIL rnd_drain: got count=%0d model=%0d expected 0/0", count, model.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_x0();
    test_fwd();
    test_midreset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
